// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port RAM with
// combinational read data.
//
// Grants are combinational (zero-cycle latency) and at most one requester is
// granted per cycle. The granted requester drives the RAM address, write data
// and write enable. A granted read captures ram_dout into rdataN at the clock
// edge and pulses rvalidN for the following cycle. rdataN holds between reads.
//
// Tie-breaking:
//   default                   : round-robin, PRI0/PRI1 state names the tie winner
//   RAM_ARB_FIXED_PRIO_EN set : requester 0 always wins ties, no priority state
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   reqN, weN, adrN, dinN         requester N request, write flag, address, data
//   gntN                          requester N is served this cycle
//   rvalidN, rdataN               requester N registered read result (1-cycle pulse)
//   ram_we, ram_adr, ram_din      RAM write enable, address, write data
//   ram_dout                      RAM combinational read data
module ram_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] adr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] adr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

`ifndef RAM_ARB_FIXED_PRIO_EN
  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;
  pri_t state;
`endif

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`else
      gnt0 = req0 & (~req1 | (state == PRI0));
      gnt1 = req1 & (~req0 | (state == PRI1));
`endif
    end
  end

  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (gnt0) begin
      ram_we  = we0;
      ram_adr = adr0;
      ram_din = din0;
    end else if (gnt1) begin
      ram_we  = we1;
      ram_adr = adr1;
      ram_din = din1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
      state   <= PRI0;
`endif
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
`ifndef RAM_ARB_FIXED_PRIO_EN
      // The requester just served loses the next tie; idle cycles hold.
      if (gnt0)
        state <= PRI1;
      else if (gnt1)
        state <= PRI0;
`endif
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0)
        rdata0 <= ram_dout;
      if (gnt1 & ~we1)
        rdata1 <= ram_dout;
    end
  end

endmodule
